demultiplexador32_buf: RTL and testbench
========================================

DEMULTIPLEXADOR32_BUF -- requirements
Module: demultiplexador32_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter DEPTH, default 2, entries per output queue; power of two, at least 2.
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sel, input, 1, destination select: 0 routes to out0, 1 routes to out1.
REQ-006 SHALL have port in_data, input, WIDTH, word to route.
REQ-007 SHALL have port in_valid, input, 1, in_data/sel valid this cycle.
REQ-008 SHALL have port in_ready, output, 1, block accepts a word this cycle.
REQ-009 SHALL have ports out0_data and out1_data, output, WIDTH, head word of each queue.
REQ-010 SHALL have ports out0_valid and out1_valid, output, 1, queue non-empty.
REQ-011 SHALL have ports out0_ready and out1_ready, input, 1, consumer takes the head word.
REQ-012 SHALL have ports count0 and count1, output, clog2(DEPTH)+1, current queue occupancy.

Function
REQ-013 SHALL accept a word when in_valid and in_ready are both 1 on a rising edge, and write it to queue sel.
REQ-014 SHALL drive in_ready = NOT full(queue selected by the current sel); purely combinational, with no dependence on outX_ready.
REQ-015 SHALL NOT push into a full queue; in_ready is 0 for a full queue even while that queue is popping the same cycle.
REQ-016 SHALL pop queue X when outX_valid and outX_ready are both 1 on a rising edge.
REQ-017 SHALL drive outX_valid = (countX != 0) and outX_data = the oldest entry of queue X, from registered state only.
REQ-018 SHALL have latency 1: a word accepted at edge N appears on outX_data with outX_valid=1 after edge N.
REQ-019 SHALL preserve order within each queue; the two queues are independent, with no ordering between them.
REQ-020 SHALL handle simultaneous push and pop on the same non-full queue: countX unchanged, both operations take effect.
REQ-021 SHALL handle simultaneous pop of out0 and out1 with a push to either queue in one cycle.
REQ-022 SHALL wrap read and write pointers modulo DEPTH; countX ranges 0..DEPTH inclusive.
REQ-023 SHALL hold outX_data stable while outX_valid=1 and outX_ready=0.
REQ-024 SHALL treat a pop on an empty queue (outX_ready=1, outX_valid=0) as a no-op.
REQ-025 SHALL ignore sel and in_data when in_valid=0.

Reset
REQ-026 SHALL, when reset_n=0, immediately and asynchronously clear: both pointer pairs to 0, count0=count1=0, out0_valid=out1_valid=0, queue storage to 0 (so out0_data=out1_data=0).
REQ-027 SHALL drive in_ready=1 during and after reset (both queues empty).
REQ-028 SHALL discard queued words on a reset mid-operation; no word accepted before reset is ever presented afterwards.
REQ-029 SHALL release reset synchronously: first push possible at the first rising edge with reset_n=1.

Structure
REQ-030 SHALL place the WIDTH default (32) and the DEPTH default (2) as constants in the shared MIPS datapath package; no typedefs are required.
REQ-031 SHALL implement each queue as one instance of sub-module fila32 (synchronous FIFO: push, pop, full, empty, count, head), instantiated twice.
REQ-032 SHALL keep the routing and handshake logic in the top module; fila32 contains no routing knowledge.

Verification
REQ-033 SHALL cover reset: assert reset_n=0 mid-cycle -> count0=count1=0, out0_valid=out1_valid=0, data=0, in_ready=1 with no clock edge.
REQ-034 SHALL cover basic routing: push 0xDEADBEEF with sel=0 and 0x12345678 with sel=1, outX_ready=0 -> out0_data=0xDEADBEEF, out1_data=0x12345678, both valid, count0=count1=1.
REQ-035 SHALL cover full behaviour: with out0_ready=0, push 0x1 and 0x2 with sel=0 -> count0=2 and in_ready=0 for sel=0; in_ready=1 for sel=1; a third push with sel=0 is not accepted.
REQ-036 SHALL cover ordering and wrap-around: stream 0x10..0x17 with sel=0 and out0_ready=1 -> out0 emits 0x10..0x17 in order; pointers wrap with no loss.
REQ-037 SHALL cover simultaneous push and pop: with count0=1 (0xA), push 0xB while popping -> count0 stays 1, out0_data=0xB.
REQ-038 SHALL cover reset mid-operation: with count0=2, pulse reset_n low -> after release out0_valid=0, and no pre-reset word ever appears.

Source files
------------

// File: rtl/demultiplexador32_buf_pkg.sv
// Shared datapath constants: default word width and per-output queue depth
// for the buffered 1-to-2 demultiplexer.
package demultiplexador32_buf_pkg;
    localparam int DATA_WIDTH  = 32;
    localparam int QUEUE_DEPTH = 2;
endpackage

// File: rtl/demultiplexador32_buf_fila32.sv
// Synchronous FIFO with registered head, asynchronous clear of pointers,
// occupancy and storage. Refuses pushes when full and pops when empty.
module fila32
    import demultiplexador32_buf_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = QUEUE_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/demultiplexador32_buf.sv
// Buffered 1-to-2 demultiplexer: routes each accepted word into one of two
// independent FIFOs selected by sel; each FIFO drains through its own port.
module demultiplexador32_buf
    import demultiplexador32_buf_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = QUEUE_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     sel,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out0_data,
    output logic                     out0_valid,
    input  logic                     out0_ready,
    output logic [WIDTH-1:0]         out1_data,
    output logic                     out1_valid,
    input  logic                     out1_ready,
    output logic [$clog2(DEPTH):0]   count0,
    output logic [$clog2(DEPTH):0]   count1
);
    logic full0, full1;
    logic empty0, empty1;
    logic push0, push1;
    logic pop0, pop1;

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both 1. in_ready looks only at the selected queue's full flag, so
    // a full queue never accepts, even while it is being drained that cycle.
    assign in_ready   = sel ? ~full1 : ~full0;
    assign push0      = in_valid & in_ready & ~sel;
    assign push1      = in_valid & in_ready & sel;
    assign out0_valid = ~empty0;
    assign out1_valid = ~empty1;
    assign pop0       = out0_valid & out0_ready;
    assign pop1       = out1_valid & out1_ready;

    fila32 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fila0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push0),
        .pop       (pop0),
        .push_data (in_data),
        .full      (full0),
        .empty     (empty0),
        .count     (count0),
        .head      (out0_data)
    );

    fila32 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fila1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push1),
        .pop       (pop1),
        .push_data (in_data),
        .full      (full1),
        .empty     (empty1),
        .count     (count1),
        .head      (out1_data)
    );
endmodule

// File: tb/tb_demultiplexador32_buf.sv
// Directed bench for the buffered demultiplexer: a per-cycle vector table
// plus hand-written sequences for streaming, wrap-around and mid-run reset.
module tb_demultiplexador32_buf;
    localparam int W = 32;

    logic          clock;
    logic          reset_n;
    logic          sel;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out0_data;
    logic          out0_valid;
    logic          out0_ready;
    logic [W-1:0]  out1_data;
    logic          out1_valid;
    logic          out1_ready;
    logic [1:0]    count0;
    logic [1:0]    count1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    demultiplexador32_buf dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sel        (sel),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .count0     (count0),
        .count1     (count1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         sel;
        logic [W-1:0] data;
        logic         valid;
        logic         r0;
        logic         r1;
        logic         exp_ready;
        logic [1:0]   c0;
        logic [1:0]   c1;
        logic         v0;
        logic         v1;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic drive(input logic s, input logic [W-1:0] d, input logic v, input logic r0, input logic r1);
        sel        = s;
        in_data    = d;
        in_valid   = v;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    initial begin
        int received;

        // sel, data, valid, r0, r1 | in_ready before edge | c0 c1 v0 v1 d0 d1 after edge
        vecs[0]  = '{1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678};
        vecs[2]  = '{1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678};
        vecs[3]  = '{1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678};
        vecs[4]  = '{1'b1, W'($urandom_range(0, 32'hFFFF)), 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678};
        vecs[5]  = '{1'b0, 32'h00000003, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1, 1'b1, 32'h00000001, 32'h12345678};
        vecs[6]  = '{1'b1, 32'h00000055, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 1'b0, 1'b1, 32'h0, 32'h00000055};
        vecs[7]  = '{1'b0, 32'h00000099, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b1, 32'h0, 32'h00000055};
        vecs[8]  = '{1'b0, 32'h0000000A, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 32'h0000000A, 32'h00000055};
        vecs[9]  = '{1'b0, 32'h0000000B, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 32'h0000000B, 32'h00000055};
        vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0};

        // Reset asserted before any clock edge: outputs must already be clear.
        reset_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        check("rst_count0", W'(count0), 32'd0);
        check("rst_count1", W'(count1), 32'd0);
        check("rst_valid0", W'(out0_valid), 32'd0);
        check("rst_valid1", W'(out1_valid), 32'd0);
        check("rst_data0", out0_data, 32'h0);
        check("rst_data1", out1_data, 32'h0);
        check("rst_in_ready", W'(in_ready), 32'd1);
        #5;
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].sel, vecs[i].data, vecs[i].valid, vecs[i].r0, vecs[i].r1);
            #1;
            check($sformatf("vec%0d_in_ready", i), W'(in_ready), W'(vecs[i].exp_ready));
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_count0", i), W'(count0), W'(vecs[i].c0));
            check($sformatf("vec%0d_count1", i), W'(count1), W'(vecs[i].c1));
            check($sformatf("vec%0d_valid0", i), W'(out0_valid), W'(vecs[i].v0));
            check($sformatf("vec%0d_valid1", i), W'(out1_valid), W'(vecs[i].v1));
            if (vecs[i].v0) check($sformatf("vec%0d_data0", i), out0_data, vecs[i].d0);
            if (vecs[i].v1) check($sformatf("vec%0d_data1", i), out1_data, vecs[i].d1);
        end

        // Stream 0x10..0x17 into out0 while draining it every cycle.
        exp_q.delete();
        received = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, W'(32'h10 + i), 1'b1, 1'b1, 1'b0);
            #1;
            check("stream_in_ready", W'(in_ready), 32'd1);
            if (out0_valid && exp_q.size() > 0) begin
                check("stream_order", out0_data, exp_q.pop_front());
                received++;
            end
            if (in_ready) exp_q.push_back(in_data);
            @(posedge clock);
            #1;
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out0_valid && exp_q.size() > 0) begin
                check("stream_order", out0_data, exp_q.pop_front());
                received++;
            end
            @(posedge clock);
            #1;
        end
        check("stream_received", W'(received), 32'd8);
        check("stream_leftover", W'(exp_q.size()), 32'd0);
        check("stream_count0_end", W'(count0), 32'd0);

        // Fill out0, then reset mid-cycle with no clock edge involved.
        drive(1'b0, 32'h77, 1'b1, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        drive(1'b0, 32'h88, 1'b1, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check("prerst_count0", W'(count0), 32'd2);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_count0", W'(count0), 32'd0);
        check("midrst_valid0", W'(out0_valid), 32'd0);
        check("midrst_data0", out0_data, 32'h0);
        check("midrst_in_ready", W'(in_ready), 32'd1);
        #2;
        reset_n = 1'b1;
        #1;
        check("postrst_valid0", W'(out0_valid), 32'd0);

        // First edge after release must already accept a word.
        drive(1'b0, 32'hC0, 1'b1, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check("postrst_push_count0", W'(count0), 32'd1);
        check("postrst_push_data0", out0_data, 32'hC0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        check("postrst_drain_valid0", W'(out0_valid), 32'd0);
        check("postrst_drain_count0", W'(count0), 32'd0);
        @(posedge clock);
        #1;
        check("postrst_no_stale_valid0", W'(out0_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
